// File: rtl/id_pkg.sv
// id_pkg: shared constants for the RV32I decode stage.
// Opcode values, ALU operation encoding and instruction field positions.
package id_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // Map funct3 to an ALU operation; alt selects SUB (f3=000) or SRA (f3=101).
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: NREGS x XLEN register file, two combinational read ports and
// one synchronous write port. x0 always reads zero and ignores writes.
// Optional macro ID_BYPASS_EN: a same-cycle write is forwarded to the readers.
module id_regfile
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] mem_q [NREGS];

    // Storage: cleared on reset, written on the clock edge when enabled (never x0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Read ports: x0 forced to zero, optional same-cycle write-through.
    always_comb begin
        rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
        rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];
`ifdef ID_BYPASS_EN
        if (we_i && (wa_i == ra1_i) && (ra1_i != '0)) rd1_o = wd_i;
        if (we_i && (wa_i == ra2_i) && (ra2_i != '0)) rd2_o = wd_i;
`else
`endif
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage. Decodes one instruction per cycle, reads
// operands from id_regfile, detects load-use hazards and registers the
// result into the ID/EX register with valid/ready handshakes on both sides.
// Optional macro ID_BYPASS_EN (register-file write-through, see id_regfile).
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src_imm,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_illegal,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [AW-1:0]   rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] dec_imm;
    alu_op_e         dec_alu_op;
    logic            dec_src_imm, dec_rw, dec_mr, dec_mw, dec_ill;
    logic            use_rs1, use_rs2;
    logic            hazard, advance, accept;

    logic            ex_valid_q, ex_src_imm_q, ex_rw_q, ex_mr_q, ex_mw_q, ex_ill_q;
    logic [XLEN-1:0] ex_pc_q, ex_rs1_q, ex_rs2_q, ex_imm_q;
    logic [AW-1:0]   ex_rd_q;
    logic [3:0]      ex_alu_op_q;

    assign opcode = if_instr[OPC_LSB +: 7];
    assign funct3 = if_instr[F3_LSB +: 3];
    assign rd_f   = if_instr[RD_LSB +: AW];
    assign rs1_f  = if_instr[RS1_LSB +: AW];
    assign rs2_f  = if_instr[RS2_LSB +: AW];

    id_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (rs1_f),
        .ra2_i (rs2_f),
        .rd1_o (rs1_data),
        .rd2_o (rs2_data),
        .we_i  (wb_we),
        .wa_i  (wb_rd),
        .wd_i  (wb_data)
    );

    // Instruction decode: immediate, ALU op, control flags and operand usage.
    always_comb begin
        dec_imm     = '0;
        dec_alu_op  = ALU_ADD;
        dec_src_imm = 1'b0;
        dec_rw      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_ill     = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        case (opcode)
            OPC_OP: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec_rw     = 1'b1;
                dec_alu_op = f3_to_alu(funct3, if_instr[F7_LSB + 5]);
            end
            OPC_OP_IMM: begin
                use_rs1     = 1'b1;
                dec_rw      = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = XLEN'($signed(if_instr[31:20]));
                // Only the shift-right immediate uses bit 30; ADDI has no SUB form.
                dec_alu_op  = f3_to_alu(funct3, (funct3 == 3'b101) && if_instr[F7_LSB + 5]);
            end
            OPC_LOAD: begin
                use_rs1     = 1'b1;
                dec_rw      = 1'b1;
                dec_mr      = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = XLEN'($signed(if_instr[31:20]));
            end
            OPC_STORE: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                dec_mw      = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
            end
            OPC_LUI: begin
                dec_rw      = 1'b1;
                dec_src_imm = 1'b1;
                dec_alu_op  = ALU_PASSB;
                dec_imm     = XLEN'($signed({if_instr[31:12], 12'b0}));
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Handshake: stall fetch on a load-use hazard, on flush, or when execute is stalled.
    always_comb begin
        hazard   = if_valid && ex_valid_q && ex_mr_q && (ex_rd_q != '0) &&
                   ((use_rs1 && (rs1_f == ex_rd_q)) || (use_rs2 && (rs2_f == ex_rd_q)));
        advance  = ex_ready || !ex_valid_q;
        id_ready = advance && !hazard && !flush;
        accept   = if_valid && id_ready;
    end

    // ID/EX register: flush clears valid, advance loads or bubbles, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_imm_q     <= '0;
            ex_rd_q      <= '0;
            ex_alu_op_q  <= '0;
            ex_src_imm_q <= 1'b0;
            ex_rw_q      <= 1'b0;
            ex_mr_q      <= 1'b0;
            ex_mw_q      <= 1'b0;
            ex_ill_q     <= 1'b0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (advance) begin
            if (accept) begin
                ex_valid_q   <= 1'b1;
                ex_pc_q      <= if_pc;
                ex_rs1_q     <= rs1_data;
                ex_rs2_q     <= rs2_data;
                ex_imm_q     <= dec_imm;
                ex_rd_q      <= rd_f;
                ex_alu_op_q  <= dec_alu_op;
                ex_src_imm_q <= dec_src_imm;
                ex_rw_q      <= dec_rw;
                ex_mr_q      <= dec_mr;
                ex_mw_q      <= dec_mw;
                ex_ill_q     <= dec_ill;
            end else begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc          = ex_pc_q;
    assign ex_rs1_data    = ex_rs1_q;
    assign ex_rs2_data    = ex_rs2_q;
    assign ex_imm         = ex_imm_q;
    assign ex_rd          = ex_rd_q;
    assign ex_alu_op      = ex_alu_op_q;
    assign ex_alu_src_imm = ex_src_imm_q;
    assign ex_reg_write   = ex_rw_q;
    assign ex_mem_read    = ex_mr_q;
    assign ex_mem_write   = ex_mw_q;
    assign ex_illegal     = ex_ill_q;

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode pipeline stage for the RV32I integer core, sitting between fetch and execute. Decodes one instruction per cycle, reads two operands from an internal 2-read/1-write register file, generates immediates and control signals, and registers them into an ID/EX pipeline register. Uses a valid/ready handshake on both sides, detects load-use hazards, and supports pipeline flush.

## Interface
Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, architectural register count (power of two, 2..32)
- AW, $clog2(NREGS), register-address width (derived)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- id_ready  out  1  stage accepts if_instr this cycle
- flush  in  1  discard ID/EX contents and the current fetch input
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  execute consumes ID/EX this cycle
- ex_pc  out  XLEN  registered PC
- ex_rs1_data, ex_rs2_data  out  XLEN  registered operands
- ex_imm  out  XLEN  sign-extended immediate
- ex_rd  out  AW  destination register
- ex_alu_op  out  4  ALU operation (id_pkg encoding)
- ex_alu_src_imm  out  1  ALU operand B is ex_imm
- ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal  out  1  control flags
- wb_we  in  1  write-back enable
- wb_rd  in  AW  write-back address
- wb_data  in  XLEN  write-back data

## Operation
- Fields: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25]; register indices truncated to AW bits.
- Supported opcodes: OP (R-type), OP-IMM, LOAD, STORE, LUI. Any other opcode: ex_illegal=1, ex_reg_write=ex_mem_read=ex_mem_write=0, ex_valid still asserted.
- Immediates: I-type imm[31:20], S-type {imm[31:25],imm[11:7]}, both sign-extended to XLEN; LUI {instr[31:12],12'b0}, alu_op=PASSB.
- rs2 is used only by OP and STORE; rs1 by all supported opcodes except LUI.
- Register file: x0 reads zero; writes to x0 ignored; synchronous write on clk when wb_we.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd!=0 & ex_rd equals a used rs1/rs2 of if_instr while if_valid.
- advance = ex_ready | !ex_valid.
- id_ready = advance & !hazard & !flush.
- On an edge with flush=1: ex_valid <= 0 (flush overrides everything).
- Else on advance: if if_valid & id_ready, load decoded instruction, ex_valid<=1; otherwise insert bubble, ex_valid<=0.
- Else (execute stalled): ID/EX holds all values.

## Timing
- Decode-to-output latency: one cycle (accepted at edge N, visible after N).
- Hazard: one bubble cycle; instruction accepted on the following advance.
- Reset (rst_n low, asynchronous): ex_valid=0, all ex_* outputs 0, every register-file entry 0; id_ready=1 after reset because ex_valid=0.
- Reset asserted mid-stall drops the held instruction.
- wb_we to x0 is no-op; simultaneous write and read of the same register follows Configuration.

## Configuration
- ID_BYPASS_EN defined: read port returns wb_data when wb_we & wb_rd==rs & rs!=0 (same-cycle write-through).
- Undefined: read returns the pre-write value; write-back must occur at least one cycle before the dependent decode.

## Structure
- id_pkg: opcode constants, alu_op encoding (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB), field position constants.
- Sub-module id_regfile (parametrised NREGS×XLEN, 2R1W, async reset, macro-controlled bypass); decode and ID/EX register in id_stage.

## Test plan
- Reset, then if_instr=0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_alu_op=ADD, ex_alu_src_imm=1, ex_reg_write=1.
- wb write x2=0xDEADBEEF, then add x3,x2,x2 (0x002101B3) -> ex_rs1_data=ex_rs2_data=0xDEADBEEF; wb write x0=7 then read x0 -> 0.
- lw x5,0(x1) followed by add x6,x5,x5 -> one bubble cycle (id_ready=0, ex_valid=0), then add issues.
- ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* held stable, id_ready=0.
- flush=1 with valid ID/EX and if_valid=1 -> next cycle ex_valid=0, input not accepted.
- Same-cycle wb x4=0x55 and decode of add x7,x4,x0 -> 0x55 with ID_BYPASS_EN, old x4 without; opcode 0x7F -> ex_illegal=1.
